// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: oversamples cs/sclk/sdo with the system clock and
// deserializes each chip-select frame into a WIDTH-bit word.
module spi_frame_receiver #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          MSB_FIRST   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cs,
   input  logic             sclk,
   input  logic             sdo,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic             busy,
   output logic [7:0]       frame_count
);

   localparam int unsigned CW    = $clog2(WIDTH + 2);
   localparam int unsigned FW    = $clog2(SYNC_STAGES + 2);
   localparam int unsigned FLUSH = SYNC_STAGES + 1;

   typedef enum logic [1:0] {StWaitIdle, StIdle, StShift} state_e;

   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdo_sync;
   logic                   cs_s, sclk_s, sdo_s;
   logic                   cs_d, sclk_d;
   logic                   cs_rise_q, cs_fall_q, sclk_rise_q, sdo_q;
   logic [FW-1:0]          flush_q;
   logic                   primed;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic [7:0]       fcount_q, fcount_d;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign sdo_s  = sdo_sync[SYNC_STAGES-1];
   assign primed = (flush_q == FW'(FLUSH));

   // Synchronizers plus one registered edge stage; sdo travels alongside so the
   // captured bit lines up with the sclk rising strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync     <= '1;
         sclk_sync   <= '0;
         sdo_sync    <= '0;
         cs_d        <= 1'b1;
         sclk_d      <= 1'b0;
         cs_rise_q   <= 1'b0;
         cs_fall_q   <= 1'b0;
         sclk_rise_q <= 1'b0;
         sdo_q       <= 1'b0;
      end else begin
         cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs};
         sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         sdo_sync    <= {sdo_sync[SYNC_STAGES-2:0], sdo};
         cs_d        <= cs_s;
         sclk_d      <= sclk_s;
         cs_rise_q   <= cs_s & ~cs_d;
         cs_fall_q   <= ~cs_s & cs_d;
         sclk_rise_q <= sclk_s & ~sclk_d;
         sdo_q       <= sdo_s;
      end
   end

   // The synchronizers reset to idle values, so cs is not trusted until the
   // real input has propagated through them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_q <= '0;
      end else if (!primed) begin
         flush_q <= flush_q + FW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StWaitIdle;
         shift_q  <= '0;
         count_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         fcount_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         count_q  <= count_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         fcount_q <= fcount_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      count_d  = count_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      busy_d   = busy_q;
      fcount_d = fcount_q;
      unique case (state_q)
         StWaitIdle: begin
            if (primed && cs_d) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (cs_fall_q) begin
               shift_d = '0;
               count_d = '0;
               busy_d  = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            // Frame end takes priority over a coincident sclk edge.
            if (cs_rise_q) begin
               if (count_q == CW'(WIDTH)) begin
                  data_d   = shift_q;
                  valid_d  = 1'b1;
                  fcount_d = fcount_q + 8'd1;
               end else begin
                  err_d = 1'b1;
               end
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (sclk_rise_q && !cs_d) begin
               if (MSB_FIRST) begin
                  shift_d = {shift_q[WIDTH-2:0], sdo_q};
               end else begin
                  shift_d = {sdo_q, shift_q[WIDTH-1:1]};
               end
               if (count_q != CW'(WIDTH + 1)) begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         default: state_d = StWaitIdle;
      endcase
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign frame_err   = err_q;
   assign busy        = busy_q;
   assign frame_count = fcount_q;

endmodule
